// File: rtl/ps2_ascii_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_ascii_tx                                                               |
// | Converts ASCII key requests into AT set-2 make/break frames on PS/2 lines. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_ascii_tx #(
  parameter int HALF_PERIOD = 1000,
  parameter int GAP_HALVES  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] ascii,
  input  logic       release_key,
  input  logic       valid,
  output logic       ready,
  output logic       unknown,
  output logic       ps2_clk,
  output logic       ps2_dat
);

  localparam int GAP_CYCLES   = GAP_HALVES * HALF_PERIOD;
  localparam int MAX_COUNT    = (GAP_CYCLES > HALF_PERIOD) ? GAP_CYCLES : HALF_PERIOD;
  localparam int CW           = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LAST_INT);
  localparam logic [3:0]    LAST_BIT  = 4'd10;
  localparam logic [7:0]    BREAK_PFX = 8'hF0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BIT_HI = 2'd1;
  localparam logic [1:0] BIT_LO = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_idx;
  logic [9:0]    r_shift;
  logic [7:0]    r_code;
  logic          r_second;

  logic       w_mapped;
  logic [7:0] w_scan;
  logic [7:0] w_tx_byte;
  logic [9:0] w_frame;
  logic       w_byte_end;

  function automatic logic [8:0] map_code(input logic [7:0] a);
    logic [7:0] f;
    f = (a >= 8'h61 && a <= 8'h7A) ? (a - 8'h20) : a;
    case (f)
      8'h41: map_code = {1'b1, 8'h1C};
      8'h42: map_code = {1'b1, 8'h32};
      8'h43: map_code = {1'b1, 8'h21};
      8'h44: map_code = {1'b1, 8'h23};
      8'h45: map_code = {1'b1, 8'h24};
      8'h46: map_code = {1'b1, 8'h2B};
      8'h47: map_code = {1'b1, 8'h34};
      8'h48: map_code = {1'b1, 8'h33};
      8'h49: map_code = {1'b1, 8'h43};
      8'h4A: map_code = {1'b1, 8'h3B};
      8'h4B: map_code = {1'b1, 8'h42};
      8'h4C: map_code = {1'b1, 8'h4B};
      8'h4D: map_code = {1'b1, 8'h3A};
      8'h4E: map_code = {1'b1, 8'h31};
      8'h4F: map_code = {1'b1, 8'h44};
      8'h50: map_code = {1'b1, 8'h4D};
      8'h51: map_code = {1'b1, 8'h15};
      8'h52: map_code = {1'b1, 8'h2D};
      8'h53: map_code = {1'b1, 8'h1B};
      8'h54: map_code = {1'b1, 8'h2C};
      8'h55: map_code = {1'b1, 8'h3C};
      8'h56: map_code = {1'b1, 8'h2A};
      8'h57: map_code = {1'b1, 8'h1D};
      8'h58: map_code = {1'b1, 8'h22};
      8'h59: map_code = {1'b1, 8'h35};
      8'h5A: map_code = {1'b1, 8'h1A};
      8'h30: map_code = {1'b1, 8'h45};
      8'h31: map_code = {1'b1, 8'h16};
      8'h32: map_code = {1'b1, 8'h1E};
      8'h33: map_code = {1'b1, 8'h26};
      8'h34: map_code = {1'b1, 8'h25};
      8'h35: map_code = {1'b1, 8'h2E};
      8'h36: map_code = {1'b1, 8'h36};
      8'h37: map_code = {1'b1, 8'h3D};
      8'h38: map_code = {1'b1, 8'h3E};
      8'h39: map_code = {1'b1, 8'h46};
      8'h20: map_code = {1'b1, 8'h29};
      8'h0D: map_code = {1'b1, 8'h5A};
      8'h08: map_code = {1'b1, 8'h66};
      8'h09: map_code = {1'b1, 8'h0D};
      8'h1B: map_code = {1'b1, 8'h76};
      8'h60: map_code = {1'b1, 8'h0E};
      8'h2D: map_code = {1'b1, 8'h4E};
      8'h3D: map_code = {1'b1, 8'h55};
      8'h5C: map_code = {1'b1, 8'h5D};
      8'h5B: map_code = {1'b1, 8'h54};
      8'h5D: map_code = {1'b1, 8'h5B};
      8'h3B: map_code = {1'b1, 8'h4C};
      8'h27: map_code = {1'b1, 8'h52};
      8'h2C: map_code = {1'b1, 8'h41};
      8'h2E: map_code = {1'b1, 8'h49};
      8'h2F: map_code = {1'b1, 8'h4A};
      default: map_code = 9'h000;
    endcase
  endfunction

  assign {w_mapped, w_scan} = map_code(ascii);

  // In IDLE the first byte comes from the live request; afterwards it is the latched scancode.
  assign w_tx_byte = (r_state == IDLE) ? (release_key ? BREAK_PFX : w_scan) : r_code;
  assign w_frame   = {1'b1, ~^w_tx_byte, w_tx_byte};

  assign w_byte_end = (r_state == GAP && r_cnt == GAP_LAST) ||
                      (GAP_CYCLES == 0 && r_state == BIT_LO &&
                       r_cnt == HALF_LAST && r_bit_idx == LAST_BIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '1;
      r_code    <= '0;
      r_second  <= 1'b0;
      ready     <= 1'b1;
      unknown   <= 1'b0;
      ps2_clk   <= 1'b1;
      ps2_dat   <= 1'b1;
    end else begin
      unknown <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid && ready) begin
            if (w_mapped) begin
              ready     <= 1'b0;
              r_code    <= w_scan;
              r_second  <= release_key;
              r_state   <= BIT_HI;
              r_cnt     <= '0;
              r_bit_idx <= '0;
              ps2_dat   <= 1'b0;
              r_shift   <= w_frame;
            end else begin
              unknown <= 1'b1;
            end
          end
        end
        BIT_HI: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            ps2_clk <= 1'b0;
            r_state <= BIT_LO;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        BIT_LO: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            ps2_clk <= 1'b1;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= GAP;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              ps2_dat   <= r_shift[0];
              r_shift   <= {1'b1, r_shift[9:1]};
              r_state   <= BIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        GAP: begin
          if (r_cnt != GAP_LAST) r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase

      // End of a byte: chain the scancode after a break prefix, else return to IDLE.
      if (w_byte_end) begin
        r_cnt <= '0;
        if (r_second) begin
          r_second  <= 1'b0;
          r_state   <= BIT_HI;
          r_bit_idx <= '0;
          ps2_dat   <= 1'b0;
          r_shift   <= w_frame;
        end else begin
          r_state <= IDLE;
          ready   <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_ascii_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_ascii_tx                                                            |
// | Directed self-checking bench for ps2_ascii_tx (HALF_PERIOD=4, GAP=4).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_ascii_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] ascii;
  logic       release_key;
  logic       valid;
  logic       ready;
  logic       unknown;
  logic       ps2_clk;
  logic       ps2_dat;

  int checks = 0;
  int errors = 0;

  ps2_ascii_tx #(.HALF_PERIOD(4), .GAP_HALVES(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ascii      (ascii),
    .release_key(release_key),
    .valid      (valid),
    .ready      (ready),
    .unknown    (unknown),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat)
  );

  always #5 clock = ~clock;

  // Line monitor: bits sampled on every ps2_clk fall, plus activity counters.
  logic prev_clk = 1'b1;
  logic prev_dat = 1'b1;
  int   cyc = 0;
  int   ready_low = 0;
  int   unk_cnt = 0;
  int   dat_viol = 0;
  logic bitq[$];
  int   fall_cyc[$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (prev_clk && !ps2_clk) begin
      bitq.push_back(ps2_dat);
      fall_cyc.push_back(cyc);
    end
    if (!prev_clk && !ps2_clk && ps2_dat !== prev_dat) dat_viol = dat_viol + 1;
    if (!ready) ready_low = ready_low + 1;
    if (unknown) unk_cnt = unk_cnt + 1;
    prev_clk = ps2_clk;
    prev_dat = ps2_dat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_at(input int base);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 11; i++)
      if (base + i < bitq.size()) f[i] = bitq[base + i];
    return f;
  endfunction

  int acc_cyc;

  task automatic send(input logic [7:0] a, input logic r);
    @(posedge clock); #1;
    ascii = a; release_key = r; valid = 1'b1;
    @(posedge clock); #1;
    acc_cyc = cyc;
    valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      if (ready) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  int b_bits, b_low, b_unk;

  initial begin
    reset_n = 1'b0; ascii = 8'h00; release_key = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready",   {31'd0, ready},   32'd1);
    check("rst_unknown", {31'd0, unknown}, 32'd0);
    check("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    check("rst_ps2_dat", {31'd0, ps2_dat}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // make 'A' -> 0x1C
    b_bits = bitq.size(); b_low = ready_low;
    send(8'h41, 1'b0);
    wait_ready("A_done");
    check("A_frame", {21'd0, frame_at(b_bits)}, {21'd0, 11'b1_0_00011100_0});
    check("A_nbits", bitq.size() - b_bits, 11);
    check("A_ready_low", ready_low - b_low, 104);
    check("A_first_fall", fall_cyc[b_bits] - acc_cyc, 5);
    check("A_bit_period", fall_cyc[b_bits + 1] - fall_cyc[b_bits], 8);

    // break 'a' -> F0 then 1C
    b_bits = bitq.size(); b_low = ready_low;
    send(8'h61, 1'b1);
    wait_ready("brk_done");
    check("brk_F0_frame", {21'd0, frame_at(b_bits)}, {21'd0, 11'b1_1_11110000_0});
    check("brk_1C_frame", {21'd0, frame_at(b_bits + 11)}, {21'd0, 11'b1_0_00011100_0});
    check("brk_nbits", bitq.size() - b_bits, 22);
    check("brk_ready_low", ready_low - b_low, 208);
    check("brk_gap", fall_cyc[b_bits + 11] - fall_cyc[b_bits + 10], 24);

    // make ' ' then 'z' presented immediately, accepted as ready rises
    b_bits = bitq.size(); b_low = ready_low;
    send(8'h20, 1'b0);
    ascii = 8'h7A; release_key = 1'b0; valid = 1'b1;
    wait_ready("sp_done");
    check("sp_ready_low", ready_low - b_low, 104);
    @(posedge clock); #1;
    valid = 1'b0;
    wait_ready("z_done");
    check("sp_frame", {21'd0, frame_at(b_bits)}, {21'd0, 11'b1_0_00101001_0});
    check("z_frame", {21'd0, frame_at(b_bits + 11)}, {21'd0, 11'b1_0_00011010_0});
    check("spz_ready_low", ready_low - b_low, 208);
    check("spz_b2b", fall_cyc[b_bits + 11] - fall_cyc[b_bits + 10], 25);

    // unmapped 0x80
    b_bits = bitq.size(); b_unk = unk_cnt;
    send(8'h80, 1'b0);
    @(negedge clock);
    check("unk_pulse", {31'd0, unknown}, 32'd1);
    check("unk_ready", {31'd0, ready}, 32'd1);
    @(negedge clock);
    check("unk_clear", {31'd0, unknown}, 32'd0);
    repeat (20) @(negedge clock);
    check("unk_count", unk_cnt - b_unk, 1);
    check("unk_no_bits", bitq.size() - b_bits, 0);
    check("unk_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);

    // reset during the data bit 3 low phase (5th fall of the frame)
    b_bits = bitq.size();
    send(8'h41, 1'b0);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        @(negedge clock);
        if (bitq.size() - b_bits >= 5) hit = 1'b1;
      end
      check("rst_mid_reach", {31'd0, hit}, 32'd1);
    end
    check("rst_mid_clk_low", {31'd0, ps2_clk}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    check("rst_mid_ready", {31'd0, ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    check("rst_abandon", bitq.size() - b_bits, 5);
    b_bits = bitq.size(); b_low = ready_low;
    send(8'h31, 1'b0);
    wait_ready("one_done");
    check("one_frame", {21'd0, frame_at(b_bits)}, {21'd0, 11'b1_0_00010110_0});
    check("one_ready_low", ready_low - b_low, 104);

    // valid held high while busy
    b_bits = bitq.size(); b_low = ready_low;
    @(posedge clock); #1;
    ascii = 8'h41; release_key = 1'b0; valid = 1'b1;
    repeat (60) @(posedge clock);
    #1 valid = 1'b0;
    wait_ready("hold_done");
    repeat (40) @(negedge clock);
    check("hold_nbits", bitq.size() - b_bits, 11);
    check("hold_ready_low", ready_low - b_low, 104);

    check("dat_stable_low", dat_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
